// File: rtl/kernel_pkg.sv
// Shared types, beat count, FSM states and the built-in kernel presets
// for the 3x3 convolution configuration path.
package kernel_pkg;

  typedef logic signed [7:0]             coef_t;
  typedef logic signed [2:0][2:0][7:0]   kernel_t;

  localparam int KERNEL_BEATS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PENDING
  } state_t;

  typedef struct packed {
    kernel_t kernel;
    coef_t   shift;
  } preset_t;

  function automatic kernel_t mk_kernel(
    input coef_t c00, input coef_t c01, input coef_t c02,
    input coef_t c10, input coef_t c11, input coef_t c12,
    input coef_t c20, input coef_t c21, input coef_t c22
  );
    kernel_t k;
    k[0][0] = c00; k[0][1] = c01; k[0][2] = c02;
    k[1][0] = c10; k[1][1] = c11; k[1][2] = c12;
    k[2][0] = c20; k[2][1] = c21; k[2][2] = c22;
    return k;
  endfunction

  localparam preset_t PRESET_IDENTITY = '{
    kernel: mk_kernel(8'sd0, 8'sd0, 8'sd0,
                      8'sd0, 8'sd1, 8'sd0,
                      8'sd0, 8'sd0, 8'sd0),
    shift:  8'sd0};

  localparam preset_t PRESET_GAUSSIAN = '{
    kernel: mk_kernel(8'sd1, 8'sd2, 8'sd1,
                      8'sd2, 8'sd4, 8'sd2,
                      8'sd1, 8'sd2, 8'sd1),
    shift:  8'sd4};

  localparam preset_t PRESET_SHARPEN = '{
    kernel: mk_kernel( 8'sd0, -8'sd1,  8'sd0,
                      -8'sd1,  8'sd5, -8'sd1,
                       8'sd0, -8'sd1,  8'sd0),
    shift:  8'sd0};

  localparam preset_t PRESET_SOBEL_X = '{
    kernel: mk_kernel(-8'sd1, 8'sd0, 8'sd1,
                      -8'sd2, 8'sd0, 8'sd2,
                      -8'sd1, 8'sd0, 8'sd1),
    shift:  8'sd0};

endpackage

// File: rtl/kernel_sequencer_if.sv
// Control-side bundle of the kernel sequencer: preset/serial load requests,
// frame boundary strobe and the active kernel handed to the datapath.
interface kernel_sequencer_if;
  import kernel_pkg::*;

  logic        frame_start_in;
  logic        preset_valid_in;
  logic [1:0]  preset_sel_in;
  logic        cfg_valid_in;
  coef_t       cfg_data_in;
  logic        cfg_ready_out;
  logic        abort_in;
  kernel_t     coeffs_out;
  coef_t       shift_out;
  logic        busy_out;
  logic        commit_out;
  logic        error_out;

  modport master (
    output frame_start_in, preset_valid_in, preset_sel_in,
           cfg_valid_in, cfg_data_in, abort_in,
    input  cfg_ready_out, coeffs_out, shift_out,
           busy_out, commit_out, error_out
  );

  modport slave (
    input  frame_start_in, preset_valid_in, preset_sel_in,
           cfg_valid_in, cfg_data_in, abort_in,
    output cfg_ready_out, coeffs_out, shift_out,
           busy_out, commit_out, error_out
  );

endinterface

// File: rtl/kernel_preset_rom.sv
// Combinational lookup of the four built-in kernels and their normaliser shifts.
module kernel_preset_rom
  import kernel_pkg::*;
(
  input  logic [1:0] preset_sel_in,
  output kernel_t    kernel_out,
  output coef_t      shift_out
);

  preset_t sel;

  always_comb begin
    sel = PRESET_IDENTITY;
    case (preset_sel_in)
      2'd0:    sel = PRESET_IDENTITY;
      2'd1:    sel = PRESET_GAUSSIAN;
      2'd2:    sel = PRESET_SHARPEN;
      default: sel = PRESET_SOBEL_X;
    endcase
  end

  assign kernel_out = sel.kernel;
  assign shift_out  = sel.shift;

endmodule

// File: rtl/kernel_sequencer.sv
// Shadow/active kernel bank controller: loads a new kernel from a preset or a
// 10-beat serial stream and swaps it in only on a frame start.
module kernel_sequencer
  import kernel_pkg::*;
#(
  parameter int SHIFT_MAX = 15
) (
  input  logic clk_in,
  input  logic rst_n_in,
  kernel_sequencer_if.slave bus
);

  state_t     state;
  logic [3:0] beat;
  kernel_t    shadow;
  coef_t      shadow_shift;
  kernel_t    active;
  coef_t      active_shift;
  logic       commit;
  logic       error;
  kernel_t    rom_kernel;
  coef_t      rom_shift;
  logic       cfg_ready;
  logic       accept;

  // Beats enter at the top and walk down, so beat 0 lands in c[0][0] after nine shifts.
  function automatic kernel_t shift_in(input kernel_t k, input coef_t d);
    logic [71:0] v;
    v = k;
    v = {d, v[71:8]};
    return kernel_t'(v);
  endfunction

  function automatic logic shift_ok(input coef_t d);
    return (d >= 8'sd0) && (int'(d) <= SHIFT_MAX);
  endfunction

  kernel_preset_rom u_rom (
    .preset_sel_in (bus.preset_sel_in),
    .kernel_out    (rom_kernel),
    .shift_out     (rom_shift)
  );

  assign cfg_ready = (state == ST_LOAD) ||
                     ((state == ST_IDLE) && !bus.preset_valid_in);
  assign accept    = bus.cfg_valid_in && cfg_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      beat         <= '0;
      shadow       <= '0;
      shadow_shift <= '0;
      active       <= PRESET_GAUSSIAN.kernel;
      active_shift <= PRESET_GAUSSIAN.shift;
      commit       <= 1'b0;
      error        <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (bus.abort_in) begin
        state        <= ST_IDLE;
        beat         <= '0;
        shadow       <= '0;
        shadow_shift <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.preset_valid_in) begin
              shadow       <= rom_kernel;
              shadow_shift <= rom_shift;
              state        <= ST_PENDING;
            end else if (accept) begin
              shadow <= shift_in(shadow, bus.cfg_data_in);
              beat   <= 4'd1;
              state  <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              if (beat == 4'(KERNEL_BEATS - 1)) begin
                beat <= '0;
                if (shift_ok(bus.cfg_data_in)) begin
                  shadow_shift <= bus.cfg_data_in;
                  state        <= ST_PENDING;
                end else begin
                  error        <= 1'b1;
                  shadow       <= '0;
                  shadow_shift <= '0;
                  state        <= ST_IDLE;
                end
              end else begin
                shadow <= shift_in(shadow, bus.cfg_data_in);
                beat   <= beat + 4'd1;
              end
            end
          end
          ST_PENDING: begin
            if (bus.frame_start_in) begin
              active       <= shadow;
              active_shift <= shadow_shift;
              commit       <= 1'b1;
              error        <= 1'b0;
              state        <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready_out = cfg_ready;
  assign bus.coeffs_out    = active;
  assign bus.shift_out     = active_shift;
  assign bus.busy_out      = (state != ST_IDLE);
  assign bus.commit_out    = commit;
  assign bus.error_out     = error;

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed bench for kernel_sequencer: presets, gapped and back-to-back
// streams, commit timing, shift rejection, abort and mid-load reset.
module tb_kernel_sequencer;

  localparam logic [71:0] K_GAUSS  = 72'h01_02_01_02_04_02_01_02_01;
  localparam logic [71:0] K_SHARP  = 72'h00_FF_00_FF_05_FF_00_FF_00;
  localparam logic [71:0] K_RAMP   = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] K_SOBEL  = 72'h01_00_FF_02_00_FE_01_00_FF;
  localparam logic [71:0] K_IDENT  = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] K_RAMP10 = 72'h12_11_10_0F_0E_0D_0C_0B_0A;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  kernel_sequencer_if bus ();

  kernel_sequencer #(.SHIFT_MAX(15)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    bus.cfg_valid_in = 1'b1;
    bus.cfg_data_in  = d;
    step();
    bus.cfg_valid_in = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start_in = 1'b1;
    step();
    bus.frame_start_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.frame_start_in  = 1'b0;
    bus.preset_valid_in = 1'b0;
    bus.preset_sel_in   = 2'd0;
    bus.cfg_valid_in    = 1'b0;
    bus.cfg_data_in     = 8'd0;
    bus.abort_in        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_coeffs", bus.coeffs_out, K_GAUSS);
    chk("rst_shift",  72'(bus.shift_out), 72'd4);
    chk("rst_busy",   72'(bus.busy_out), 72'd0);
    chk("rst_error",  72'(bus.error_out), 72'd0);
    chk("rst_commit", 72'(bus.commit_out), 72'd0);
    chk("rst_ready",  72'(bus.cfg_ready_out), 72'd1);

    // Preset 2 (sharpen), committed five cycles later
    bus.preset_valid_in = 1'b1;
    bus.preset_sel_in   = 2'd2;
    #1;
    chk("preset_ready_low", 72'(bus.cfg_ready_out), 72'd0);
    step();
    bus.preset_valid_in = 1'b0;
    chk("preset_busy", 72'(bus.busy_out), 72'd1);
    for (int i = 0; i < 4; i++) step();
    chk("preset_busy_hold",   72'(bus.busy_out), 72'd1);
    chk("preset_coeffs_hold", bus.coeffs_out, K_GAUSS);
    chk("preset_no_commit",   72'(bus.commit_out), 72'd0);
    frame();
    chk("sharp_commit", 72'(bus.commit_out), 72'd1);
    chk("sharp_coeffs", bus.coeffs_out, K_SHARP);
    chk("sharp_shift",  72'(bus.shift_out), 72'd0);
    chk("sharp_busy",   72'(bus.busy_out), 72'd0);
    step();
    chk("sharp_commit_once", 72'(bus.commit_out), 72'd0);

    // Gapped stream 1..9, shift 3; a preset request mid-load is ignored
    for (int i = 0; i < 10; i++) begin
      beat((i < 9) ? 8'(i + 1) : 8'd3);
      if (i == 4) begin
        chk("load_ready", 72'(bus.cfg_ready_out), 72'd1);
        bus.preset_valid_in = 1'b1;
        bus.preset_sel_in   = 2'd0;
      end
      step();
      bus.preset_valid_in = 1'b0;
    end
    chk("pend_ready_low", 72'(bus.cfg_ready_out), 72'd0);
    chk("pend_busy",      72'(bus.busy_out), 72'd1);
    chk("pend_coeffs",    bus.coeffs_out, K_SHARP);
    frame();
    chk("ramp_commit", 72'(bus.commit_out), 72'd1);
    chk("ramp_coeffs", bus.coeffs_out, K_RAMP);
    chk("ramp_shift",  72'(bus.shift_out), 72'd3);
    step();

    // Back-to-back sobel-x stream; frame start on the shift beat must not commit
    beat(8'hFF); beat(8'h00); beat(8'h01);
    beat(8'hFE); beat(8'h00); beat(8'h02);
    beat(8'hFF); beat(8'h00); beat(8'h01);
    bus.frame_start_in = 1'b1;
    beat(8'h00);
    bus.frame_start_in = 1'b0;
    chk("same_cycle_no_commit", 72'(bus.commit_out), 72'd0);
    chk("same_cycle_coeffs",    bus.coeffs_out, K_RAMP);
    chk("same_cycle_busy",      72'(bus.busy_out), 72'd1);
    step();
    frame();
    chk("sobel_commit", 72'(bus.commit_out), 72'd1);
    chk("sobel_coeffs", bus.coeffs_out, K_SOBEL);
    chk("sobel_shift",  72'(bus.shift_out), 72'd0);
    step();

    // Out-of-range shift beat is rejected
    for (int i = 0; i < 9; i++) beat(8'h00);
    beat(8'd20);
    chk("err_set",    72'(bus.error_out), 72'd1);
    chk("err_idle",   72'(bus.busy_out), 72'd0);
    chk("err_coeffs", bus.coeffs_out, K_SOBEL);
    chk("err_ready",  72'(bus.cfg_ready_out), 72'd1);
    frame();
    chk("err_idle_frame_no_commit", 72'(bus.commit_out), 72'd0);
    bus.preset_valid_in = 1'b1;
    bus.preset_sel_in   = 2'd0;
    step();
    bus.preset_valid_in = 1'b0;
    chk("err_sticky", 72'(bus.error_out), 72'd1);
    frame();
    chk("ident_commit", 72'(bus.commit_out), 72'd1);
    chk("err_cleared",  72'(bus.error_out), 72'd0);
    chk("ident_coeffs", bus.coeffs_out, K_IDENT);
    step();

    // Abort in PENDING coinciding with frame start
    bus.preset_valid_in = 1'b1;
    bus.preset_sel_in   = 2'd1;
    step();
    bus.preset_valid_in = 1'b0;
    bus.abort_in        = 1'b1;
    frame();
    bus.abort_in = 1'b0;
    chk("abort_no_commit", 72'(bus.commit_out), 72'd0);
    chk("abort_coeffs",    bus.coeffs_out, K_IDENT);
    chk("abort_idle",      72'(bus.busy_out), 72'd0);
    frame();
    chk("abort_later_frame", 72'(bus.commit_out), 72'd0);

    // Reset during beat 5 restores gaussian and restarts at beat 0
    for (int i = 0; i < 5; i++) beat(8'd7);
    bus.cfg_valid_in = 1'b1;
    bus.cfg_data_in  = 8'd7;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_coeffs", bus.coeffs_out, K_GAUSS);
    chk("mid_rst_shift",  72'(bus.shift_out), 72'd4);
    chk("mid_rst_busy",   72'(bus.busy_out), 72'd0);
    bus.cfg_valid_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 9; i++) beat(8'(10 + i));
    chk("restart_still_loading", 72'(bus.cfg_ready_out), 72'd1);
    beat(8'd2);
    chk("restart_pending", 72'(bus.cfg_ready_out), 72'd0);
    frame();
    chk("restart_commit", 72'(bus.commit_out), 72'd1);
    chk("restart_coeffs", bus.coeffs_out, K_RAMP10);
    chk("restart_shift",  72'(bus.shift_out), 72'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
